// File: rtl/spi_fl_read_seq.sv
// Burst-read sequencer: splits one (start_addr, nbytes) request into single-byte
// SPI flash READ transactions and packs the returned bytes into 32-bit words.
module spi_fl_read_seq #(
    parameter logic [7:0] READ_CMD    = 8'h03,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      start_addr,
    input  logic [CNT_W-1:0] nbytes,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [31:0]      word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [7:0]       m_command,
    output logic [23:0]      m_address,
    output logic [7:0]       m_data_in,
    output logic             m_validflag,
    input  logic [7:0]       m_data_out,
    input  logic             m_validflag_out
);

    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

    state_t           state, state_n;
    logic [23:0]      cur_addr;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       lane;
    logic             vfo_q;
    logic [WC_W-1:0]  wait_cnt;
    logic             strobe;
    logic             timeout_hit;

    // The master may hold validflag_out for several cycles; only its rising edge is a byte.
    assign strobe      = (state == WAIT) && m_validflag_out && !vfo_q;
    assign timeout_hit = (state == WAIT) && !strobe && (wait_cnt == WC_W'(TIMEOUT_CYC - 1));

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign word_valid  = (state == OUT);
    assign m_validflag = (state == ISSUE);
    assign m_command   = READ_CMD;
    assign m_address   = cur_addr;
    assign m_data_in   = 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = (nbytes != '0) ? ISSUE : DONE;
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (strobe)
                    state_n = (lane == 2'd3 || remaining == CNT_W'(1)) ? OUT : ISSUE;
                else if (timeout_hit)
                    state_n = DONE;
            end
            // Holding here while a word is pending is what stalls further reads.
            OUT:   if (word_ready) state_n = (remaining == '0) ? DONE : ISSUE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr    <= '0;
            remaining   <= '0;
            lane        <= '0;
            word_out    <= '0;
            err_timeout <= 1'b0;
            vfo_q       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            vfo_q    <= m_validflag_out;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr    <= start_addr;
                        remaining   <= nbytes;
                        lane        <= '0;
                        word_out    <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                WAIT: begin
                    if (strobe) begin
                        word_out[{lane, 3'b000} +: 8] <= m_data_out;
                        cur_addr  <= cur_addr + 24'd1;
                        remaining <= remaining - 1'b1;
                        lane      <= lane + 2'd1;
                    end else if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        word_out    <= '0;
                        lane        <= '0;
                    end
                end
                OUT: begin
                    if (word_ready) begin
                        lane     <= '0;
                        word_out <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
